// File: rtl/keycode_evt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keycode_evt_pkg
// Purpose  : Shared types for the keycode event controller and its FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package keycode_evt_pkg;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'd0,
        EVT_RELEASE = 2'd1,
        EVT_REPEAT  = 2'd2
    } evt_type_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0] code;
        evt_type_t  etype;
    } evt_t;

    function automatic evt_t mk_evt(input logic [7:0] code, input evt_type_t etype);
        evt_t e;
        e.code  = code;
        e.etype = etype;
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keycode_event_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : keycode_event_ctrl_if
// Purpose  : Valid/ready event channel from the controller to game logic.
// Revision : 1.0 - initial release
// ============================================================================
interface keycode_event_ctrl_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic [1:0] evt_type;

    modport master (output evt_valid, output evt_code, output evt_type, input  evt_ready);
    modport slave  (input  evt_valid, input  evt_code, input  evt_type, output evt_ready);
endinterface
`default_nettype wire

// File: rtl/keycode_evt_fifo.sv
`default_nettype none
// ============================================================================
// Module   : keycode_evt_fifo
// Purpose  : Show-ahead event FIFO; a push into a full FIFO is still accepted
//            when a pop happens on the same edge.
// Revision : 1.0 - initial release
// ============================================================================
module keycode_evt_fifo
    import keycode_evt_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic                          clk,
    input  wire logic                          reset_n,
    input  wire logic                          i_push,
    input  wire evt_t                          i_push_evt,
    input  wire logic                          i_pop_rdy,
    output      logic                          o_valid,
    output      evt_t                          o_head,
    output      logic [$clog2(FIFO_DEPTH):0]   o_count,
    output      logic                          o_drop
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] c_FULL_CNT = CW'(FIFO_DEPTH);

    evt_t            r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_wr;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL_CNT);
    assign w_pop   = !w_empty && i_pop_rdy;
    assign w_wr    = i_push && (!w_full || w_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= i_push_evt;
    end

    assign o_valid = !w_empty;
    assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_drop  = i_push && w_full && !w_pop;

endmodule
`default_nettype wire

// File: rtl/keycode_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : keycode_event_ctrl
// Purpose  : Converts a level keycode into PRESS/RELEASE/REPEAT events with
//            typematic auto-repeat, buffered for a valid/ready consumer.
// Revision : 1.0 - initial release
// ============================================================================
module keycode_event_ctrl
    import keycode_evt_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 2500000,
    parameter int CNT_W         = 25
) (
    input  wire logic                          clk,
    input  wire logic                          reset_n,
    input  wire logic [7:0]                    i_keycode_in,
    input  wire logic                          i_repeat_en,
    input  wire logic                          i_ovf_clr,
    keycode_event_ctrl_if.master               evt_if,
    output      logic [7:0]                    o_held_code,
    output      logic                          o_overflow,
    output      logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

    localparam logic [CNT_W-1:0] c_DELAY_LD  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] c_PERIOD_LD = CNT_W'(REPEAT_PERIOD - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [7:0]        r_prev_code;
    logic [7:0]        w_prev_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_ovf;

    logic              w_push;
    evt_t              w_push_evt;
    evt_t              w_head;
    logic              w_drop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_prev_code <= '0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_prev_code <= w_prev_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    // A key change always releases the old key first, so A->B takes two edges.
    always_comb begin
        w_state_nxt = r_state;
        w_prev_nxt  = r_prev_code;
        w_cnt_nxt   = r_cnt;
        w_push      = 1'b0;
        w_push_evt  = '0;
        if (i_keycode_in != r_prev_code) begin
            if (r_prev_code != 8'h00) begin
                w_push      = 1'b1;
                w_push_evt  = mk_evt(r_prev_code, EVT_RELEASE);
                w_prev_nxt  = 8'h00;
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end else begin
                w_push      = 1'b1;
                w_push_evt  = mk_evt(i_keycode_in, EVT_PRESS);
                w_prev_nxt  = i_keycode_in;
                w_cnt_nxt   = c_DELAY_LD;
                w_state_nxt = S_DELAY;
            end
        end else if ((r_prev_code != 8'h00) && (r_state != S_IDLE)) begin
            if (r_cnt != '0) begin
                w_cnt_nxt = r_cnt - 1'b1;
            end else if (i_repeat_en) begin
                w_push      = 1'b1;
                w_push_evt  = mk_evt(r_prev_code, EVT_REPEAT);
                w_cnt_nxt   = c_PERIOD_LD;
                w_state_nxt = S_REPEAT;
            end
        end
    end

    keycode_evt_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_push     (w_push),
        .i_push_evt (w_push_evt),
        .i_pop_rdy  (evt_if.evt_ready),
        .o_valid    (evt_if.evt_valid),
        .o_head     (w_head),
        .o_count    (o_fifo_count),
        .o_drop     (w_drop)
    );

    // Setting wins over a coincident clear so a drop is never lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_ovf <= 1'b0;
        else if (w_drop)
            r_ovf <= 1'b1;
        else if (i_ovf_clr)
            r_ovf <= 1'b0;
    end

    assign evt_if.evt_code = w_head.code;
    assign evt_if.evt_type = w_head.etype;
    assign o_held_code     = r_prev_code;
    assign o_overflow      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_keycode_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_keycode_event_ctrl
// Purpose  : Directed self-checking bench for keycode_event_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keycode_event_ctrl;

    localparam int FIFO_DEPTH    = 4;
    localparam int REPEAT_DELAY  = 8;
    localparam int REPEAT_PERIOD = 3;
    localparam int CNT_W         = 4;

    localparam logic [1:0] c_PRESS   = 2'd0;
    localparam logic [1:0] c_RELEASE = 2'd1;
    localparam logic [1:0] c_REPEAT  = 2'd2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] keycode;
    logic       repeat_en;
    logic       ovf_clr;
    logic [7:0] held;
    logic       ovf;
    logic [2:0] count;

    int vectors = 0;
    int errors  = 0;

    keycode_event_ctrl_if evt_if();

    keycode_event_ctrl #(
        .FIFO_DEPTH    (FIFO_DEPTH),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD),
        .CNT_W         (CNT_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_keycode_in (keycode),
        .i_repeat_en  (repeat_en),
        .i_ovf_clr    (ovf_clr),
        .evt_if       (evt_if),
        .o_held_code  (held),
        .o_overflow   (ovf),
        .o_fifo_count (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // {valid, code, type}
    function automatic logic [10:0] ev(input logic v, input logic [7:0] c, input logic [1:0] t);
        return {v, c, t};
    endfunction

    function automatic logic [10:0] head();
        return {evt_if.evt_valid, evt_if.evt_code, evt_if.evt_type};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        keycode = 8'h00;
        repeat_en = 1'b1;
        ovf_clr = 1'b0;
        evt_if.evt_ready = 1'b1;
        #12;
        vectors++;
        if ({head(), held, ovf, count} !== 23'd0) begin
            $display("FAIL reset_state: got %h want 0", {head(), held, ovf, count});
            errors++;
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_press_repeat();
        logic [10:0] exp;
        keycode = 8'h04;
        for (int e = 0; e <= 14; e++) begin
            step();
            if (e == 0)
                exp = ev(1'b1, 8'h04, c_PRESS);
            else if (e == 8 || e == 11 || e == 14)
                exp = ev(1'b1, 8'h04, c_REPEAT);
            else
                exp = 11'd0;
            vectors++;
            if (head() !== exp) begin
                $display("FAIL press_repeat edge %0d: got %h want %h", e, head(), exp);
                errors++;
            end
        end
        vectors++;
        if (held !== 8'h04) begin
            $display("FAIL held_code: got %h want 04", held);
            errors++;
        end
    endtask

    task automatic test_key_change();
        keycode = 8'h05;
        step();
        vectors++;
        if (head() !== ev(1'b1, 8'h04, c_RELEASE)) begin
            $display("FAIL change_release: got %h want %h", head(), ev(1'b1, 8'h04, c_RELEASE));
            errors++;
        end
        step();
        vectors++;
        if ({head(), held} !== {ev(1'b1, 8'h05, c_PRESS), 8'h05}) begin
            $display("FAIL change_press: got %h want %h", {head(), held}, {ev(1'b1, 8'h05, c_PRESS), 8'h05});
            errors++;
        end
        keycode = 8'h00;
        step();
        vectors++;
        if (head() !== ev(1'b1, 8'h05, c_RELEASE)) begin
            $display("FAIL key_up_release: got %h want %h", head(), ev(1'b1, 8'h05, c_RELEASE));
            errors++;
        end
        for (int i = 0; i < 12; i++) begin
            step();
            vectors++;
            if ({head(), held} !== 19'd0) begin
                $display("FAIL idle_quiet cycle %0d: got %h want 0", i, {head(), held});
                errors++;
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0]  codes [5];
        logic [10:0] exp_d [4];
        codes = '{8'h07, 8'h00, 8'h07, 8'h00, 8'h07};
        evt_if.evt_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            keycode = codes[i];
            step();
        end
        vectors++;
        if ({count, ovf, head()} !== {3'd4, 1'b1, ev(1'b1, 8'h07, c_PRESS)}) begin
            $display("FAIL overflow_set: got %h want %h", {count, ovf, head()}, {3'd4, 1'b1, ev(1'b1, 8'h07, c_PRESS)});
            errors++;
        end
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        vectors++;
        if ({count, ovf} !== {3'd4, 1'b0}) begin
            $display("FAIL overflow_clear: got %h want %h", {count, ovf}, {3'd4, 1'b0});
            errors++;
        end
        exp_d = '{ev(1'b1, 8'h07, c_RELEASE), ev(1'b1, 8'h07, c_PRESS),
                  ev(1'b1, 8'h07, c_RELEASE), 11'd0};
        evt_if.evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if ({count, head()} !== {3'(3 - i), exp_d[i]}) begin
                $display("FAIL drain %0d: got %h want %h", i, {count, head()}, {3'(3 - i), exp_d[i]});
                errors++;
            end
        end
        keycode = 8'h00;
        step();
        vectors++;
        if (head() !== ev(1'b1, 8'h07, c_RELEASE)) begin
            $display("FAIL ovf_release: got %h want %h", head(), ev(1'b1, 8'h07, c_RELEASE));
            errors++;
        end
        step();
    endtask

    task automatic test_full_push_pop();
        logic [10:0] exp_d [4];
        evt_if.evt_ready = 1'b0;
        keycode = 8'h07; step();
        keycode = 8'h00; step();
        keycode = 8'h07; step();
        repeat (REPEAT_DELAY) step();
        vectors++;
        if ({count, ovf, head()} !== {3'd4, 1'b0, ev(1'b1, 8'h07, c_PRESS)}) begin
            $display("FAIL full_fill: got %h want %h", {count, ovf, head()}, {3'd4, 1'b0, ev(1'b1, 8'h07, c_PRESS)});
            errors++;
        end
        keycode = 8'h00;
        evt_if.evt_ready = 1'b1;
        step();
        vectors++;
        if ({count, ovf, head()} !== {3'd4, 1'b0, ev(1'b1, 8'h07, c_RELEASE)}) begin
            $display("FAIL full_push_pop: got %h want %h", {count, ovf, head()}, {3'd4, 1'b0, ev(1'b1, 8'h07, c_RELEASE)});
            errors++;
        end
        exp_d = '{ev(1'b1, 8'h07, c_PRESS), ev(1'b1, 8'h07, c_REPEAT),
                  ev(1'b1, 8'h07, c_RELEASE), 11'd0};
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if ({count, head()} !== {3'(3 - i), exp_d[i]}) begin
                $display("FAIL full_drain %0d: got %h want %h", i, {count, head()}, {3'(3 - i), exp_d[i]});
                errors++;
            end
        end
    endtask

    task automatic test_repeat_disable();
        int presses;
        int others;
        presses = 0;
        others  = 0;
        repeat_en = 1'b0;
        keycode = 8'h04;
        for (int i = 0; i < 30; i++) begin
            step();
            if (head() == ev(1'b1, 8'h04, c_PRESS))
                presses++;
            else if (evt_if.evt_valid)
                others++;
        end
        vectors++;
        if (presses != 1 || others != 0) begin
            $display("FAIL repeat_disabled: got %0d press %0d other want 1 press 0 other", presses, others);
            errors++;
        end
        repeat_en = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            step();
            vectors++;
            if (head() !== ((e % 3 == 0) ? ev(1'b1, 8'h04, c_REPEAT) : 11'd0)) begin
                $display("FAIL repeat_enable edge %0d: got %h want %h", e, head(),
                         (e % 3 == 0) ? ev(1'b1, 8'h04, c_REPEAT) : 11'd0);
                errors++;
            end
        end
    endtask

    task automatic test_async_reset();
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({head(), held, ovf, count} !== 23'd0) begin
            $display("FAIL async_reset: got %h want 0", {head(), held, ovf, count});
            errors++;
        end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int e = 0; e <= 8; e++) begin
            step();
            vectors++;
            if (head() !== ((e == 0) ? ev(1'b1, 8'h04, c_PRESS) :
                            (e == 8) ? ev(1'b1, 8'h04, c_REPEAT) : 11'd0)) begin
                $display("FAIL post_reset edge %0d: got %h", e, head());
                errors++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_press_repeat();
        test_key_change();
        test_overflow();
        test_full_push_pop();
        test_repeat_disable();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
